pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline.
// Load-use, branch flush, dmem freeze, watchdog, stats.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic [1:0]       state,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FAULT    = 2'b11
  } state_t;

  state_t          cur, nxt;
  logic [WW-1:0]   wait_cnt;
  logic            load_use;

  assign state = cur;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) ||
                     (id_uses_rt && (ex_rt == id_rt)));

  // Prioritised control decode and next-state selection
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    nxt         = RUN;
    if (cur == FAULT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      nxt         = FAULT;
    end else if (dmem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      nxt = (wait_cnt == WAIT_LAST) ? FAULT : MEM_WAIT;
    end else if (load_use) begin
      // ID is held, so a coincident branch is seen again next cycle
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      nxt         = LU_STALL;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= RUN;
    else     cur <= nxt;
  end

  // Consecutive-busy watchdog counter; any idle cycle restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (!dmem_busy)
      wait_cnt <= '0;
    else if (cur != FAULT && wait_cnt != WAIT_LAST)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky fault flag, set on the transition into FAULT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               mem_fault <= 1'b0;
    else if (nxt == FAULT) mem_fault <= 1'b1;
  end

  // Saturating stall counter (freeze or load-use, not FAULT)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (cur != FAULT && !pc_write && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Saturating flush counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flush_cnt <= '0;
    else if (ifid_flush && flush_cnt != CNT_MAX)
      flush_cnt <= flush_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
// Wide-counter and 2-bit-counter instances share stimulus.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_RUN = 7'b1101011;
  localparam logic [6:0] C_LU  = 7'b0001111;
  localparam logic [6:0] C_BR  = 7'b1111011;
  localparam logic [6:0] C_FRZ = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, dmem_busy;

  logic        pc_write, ifid_write, ifid_flush, idex_write;
  logic        idex_bubble, exmem_write, memwb_write, mem_fault;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_write2, ifid_write2, ifid_flush2, idex_write2;
  logic        idex_bubble2, exmem_write2, memwb_write2, mem_fault2;
  logic [1:0]  state2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [1:0]  st;
    logic        mf;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [1:0]  sc2;
    logic [1:0]  fc2;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .memwb_write(memwb_write), .state(state),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_write(idex_write2),
    .idex_bubble(idex_bubble2), .exmem_write(exmem_write2),
    .memwb_write(memwb_write2), .state(state2),
    .mem_fault(mem_fault2), .stall_cnt(stall_cnt2),
    .flush_cnt(flush_cnt2)
  );

  function automatic logic [1:0] sat3(input int v);
    return (v > 3) ? 2'd3 : v[1:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] c, input logic [1:0] st,
                      input logic mf, input int sc, input int fc);
    exp_t e;
    e.ctrl = c;
    e.st   = st;
    e.mf   = mf;
    e.sc   = sc[15:0];
    e.fc   = fc[15:0];
    e.sc2  = sat3(sc);
    e.fc2  = sat3(fc);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".ctrl"}, {9'd0, pc_write, ifid_write, ifid_flush,
          idex_write, idex_bubble, exmem_write, memwb_write},
          {9'd0, e.ctrl});
      chk({tag, ".ctrl2"}, {9'd0, pc_write2, ifid_write2, ifid_flush2,
          idex_write2, idex_bubble2, exmem_write2, memwb_write2},
          {9'd0, e.ctrl});
      chk({tag, ".state"}, {14'd0, state}, {14'd0, e.st});
      chk({tag, ".state2"}, {14'd0, state2}, {14'd0, e.st});
      chk({tag, ".mem_fault"}, {15'd0, mem_fault}, {15'd0, e.mf});
      chk({tag, ".mem_fault2"}, {15'd0, mem_fault2}, {15'd0, e.mf});
      chk({tag, ".stall_cnt"}, stall_cnt, e.sc);
      chk({tag, ".flush_cnt"}, flush_cnt, e.fc);
      chk({tag, ".stall_cnt2"}, {14'd0, stall_cnt2}, {14'd0, e.sc2});
      chk({tag, ".flush_cnt2"}, {14'd0, flush_cnt2}, {14'd0, e.fc2});
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic [4:0] xrt,
                       input logic mr, input logic br,
                       input logic busy);
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = uses;
    ex_rt        = xrt;
    ex_mem_read  = mr;
    branch_taken = br;
    dmem_busy    = busy;
  endtask

  // one cycle: drive after posedge, check at negedge
  task automatic step(input string tag,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic [4:0] xrt,
                      input logic mr, input logic br,
                      input logic busy,
                      input logic [6:0] c, input logic [1:0] st,
                      input logic mf, input int sc, input int fc);
    drive(rs, rt, uses, xrt, mr, br, busy);
    push(c, st, mf, sc, fc);
    @(negedge clk);
    pop_check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag, input logic [6:0] c,
                       input logic [1:0] st, input logic mf,
                       input int sc, input int fc);
    step(tag, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
         c, st, mf, sc, fc);
  endtask

  task automatic rst_pulse(input string tag);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    push(C_RUN, 2'b00, 1'b0, 0, 0);
    #2;
    pop_check(tag);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push(C_RUN, 2'b00, 1'b0, 0, 0);
    @(negedge clk);
    pop_check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("rt_gated", 5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0,
         C_RUN, 2'b00, 1'b0, 0, 0);
    step("zero_reg", 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0,
         C_RUN, 2'b00, 1'b0, 0, 0);
    step("lu_rs", 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0,
         C_LU, 2'b00, 1'b0, 0, 0);
    quiet("lu_after", C_RUN, 2'b01, 1'b0, 1, 0);
    quiet("lu_run", C_RUN, 2'b00, 1'b0, 1, 0);
    step("lu_rt_br", 5'd2, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0,
         C_LU, 2'b00, 1'b0, 1, 0);
    step("br_alone", 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0,
         C_BR, 2'b01, 1'b0, 2, 0);
    quiet("br_after", C_RUN, 2'b00, 1'b0, 2, 1);

    for (int k = 1; k <= 5; k++)
      step("freeze", 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1,
           C_FRZ, (k == 1) ? 2'b00 : 2'b10, 1'b0, 1 + k, 1);
    quiet("frz_release", C_RUN, 2'b10, 1'b0, 7, 1);
    quiet("frz_run", C_RUN, 2'b00, 1'b0, 7, 1);

    for (int j = 1; j <= 15; j++)
      step("busy15", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
           C_FRZ, (j == 1) ? 2'b00 : 2'b10, 1'b0, 6 + j, 1);
    quiet("gap", C_RUN, 2'b10, 1'b0, 22, 1);
    step("rebusy1", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
         C_FRZ, 2'b00, 1'b0, 22, 1);
    step("rebusy2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
         C_FRZ, 2'b10, 1'b0, 23, 1);
    quiet("no_fault", C_RUN, 2'b10, 1'b0, 24, 1);
    quiet("pre_wd", C_RUN, 2'b00, 1'b0, 24, 1);

    for (int k = 1; k <= 16; k++)
      step("watchdog", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
           C_FRZ, (k == 1) ? 2'b00 : 2'b10, 1'b0, 23 + k, 1);
    quiet("fault", C_FRZ, 2'b11, 1'b1, 40, 1);
    step("fault_hold", 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1,
         C_FRZ, 2'b11, 1'b1, 40, 1);

    rst_pulse("rst_fault");

    for (int n = 1; n <= 5; n++) begin
      step("sat_lu", 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0,
           C_LU, 2'b00, 1'b0, n - 1, 0);
      quiet("sat_run", C_RUN, 2'b01, 1'b0, n, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
